// File: rtl/edge_event_encoder_8to3.sv
// Rising-edge capture on eight event lines, presented as a 3-bit code
// with valid/ready; highest pending index goes first.
module edge_event_encoder_8to3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       ready,
  output logic [2:0] Y,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] d_q;
  logic [7:0] edge_v;
  logic [7:0] acc_mask;
  logic [7:0] rem;
  logic [2:0] y_nx;
  logic       xfer;

  function automatic logic [2:0] sel(input logic [7:0] v);
    sel = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) sel = 3'(i);
  endfunction

  assign edge_v   = D & ~d_q;
  assign valid    = (state == PRESENT);
  assign xfer     = valid & ready;
  assign acc_mask = xfer ? (8'd1 << Y) : 8'd0;
  // A fresh edge on the accepted line re-arms it.
  assign rem      = (pending & ~acc_mask) | edge_v;

  always_comb begin
    state_nx = state;
    y_nx     = Y;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          y_nx     = sel(pending);
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (|rem) y_nx = sel(rem);
          else      state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q      <= 8'd0;
      pending  <= 8'd0;
      overflow <= 1'b0;
      Y        <= 3'd0;
      state    <= IDLE;
    end else begin
      d_q      <= D;
      pending  <= rem;
      overflow <= overflow | (|(edge_v & pending & ~acc_mask));
      Y        <= y_nx;
      state    <= state_nx;
    end
  end

endmodule

// File: tb/tb_edge_event_encoder_8to3.sv
// Bench for edge_event_encoder_8to3: directed scenarios plus random
// traffic against a cycle-level reference model.
module tb_edge_event_encoder_8to3;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       ready;
  logic [2:0] Y;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_dq;
  logic [7:0] m_pend;
  logic       m_valid;
  logic       m_ovf;
  logic [2:0] m_y;

  edge_event_encoder_8to3 dut (
    .clk(clk),
    .rst(rst),
    .D(D),
    .ready(ready),
    .Y(Y),
    .valid(valid),
    .pending(pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int msb(input int x);
    return $clog2(x + 1) - 1;
  endfunction

  task automatic model_reset();
    m_dq = 0; m_pend = 0; m_valid = 0; m_ovf = 0; m_y = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic r);
    logic [7:0] e, acc, rm;
    logic x;
    e   = d & ~m_dq;
    x   = m_valid && r;
    acc = x ? 8'(1 << m_y) : 8'd0;
    rm  = (m_pend & ~acc) | e;
    if ((e & m_pend & ~acc) != 0) m_ovf = 1'b1;
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_y = 3'(msb(int'(m_pend)));
        m_valid = 1'b1;
      end
    end else if (x) begin
      if (rm != 0) m_y = 3'(msb(int'(rm)));
      else m_valid = 1'b0;
    end
    m_pend = rm;
    m_dq = d;
  endtask

  task automatic tick(input logic [7:0] d, input logic r);
    D = d;
    ready = r;
    model_step(d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    D = 8'd0;
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(8'hFF, 1'b0);
    tick(8'hFF, 1'b0);
    checks++;
    if (!(valid === 1'b1 && Y === 3'd7)) begin
      errors++;
      $display("FAIL pre_reset: valid=%b Y=%0d want valid=1 Y=7", valid, Y);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({valid, pending, overflow, Y} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b pend=%h ovf=%b Y=%0d want all 0",
               valid, pending, overflow, Y);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(8'hFF, 1'b0);
    checks++;
    if (!(pending === 8'hFF && valid === 1'b0)) begin
      errors++;
      $display("FAIL reset_release: pend=%h valid=%b want FF 0", pending, valid);
    end
    tick(8'hFF, 1'b0);
    checks++;
    if (!(valid === 1'b1 && Y === 3'd7)) begin
      errors++;
      $display("FAIL reset_first: valid=%b Y=%0d want 1 7", valid, Y);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 9; i++) tick(8'h00, 1'b1);
    checks++;
    if (!(valid === 1'b0 && pending === 8'h00)) begin
      errors++;
      $display("FAIL drain: valid=%b pend=%h want 0 00", valid, pending);
    end
    tick(8'h08, 1'b0);
    checks++;
    if (!(valid === 1'b0 && pending === 8'h08)) begin
      errors++;
      $display("FAIL single_t0: valid=%b pend=%h want 0 08", valid, pending);
    end
    tick(8'h08, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!(valid === 1'b1 && Y === 3'd3)) begin
        errors++;
        $display("FAIL single_hold%0d: valid=%b Y=%0d want 1 3", i, valid, Y);
      end
      tick(8'h08, 1'b0);
    end
    tick(8'h08, 1'b1);
    checks++;
    if (!(valid === 1'b0 && pending === 8'h00)) begin
      errors++;
      $display("FAIL single_acc: valid=%b pend=%h want 0 00", valid, pending);
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp_y [3];
    exp_y = '{3'd5, 3'd2, 3'd0};
    tick(8'h00, 1'b0);
    tick(8'h25, 1'b1);
    checks++;
    if (!(pending === 8'h25 && valid === 1'b0)) begin
      errors++;
      $display("FAIL burst_latch: pend=%h valid=%b want 25 0", pending, valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick(8'h25, 1'b1);
      checks++;
      if (!(valid === 1'b1 && Y === exp_y[i])) begin
        errors++;
        $display("FAIL burst%0d: valid=%b Y=%0d want 1 %0d",
                 i, valid, Y, exp_y[i]);
      end
    end
    tick(8'h25, 1'b1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: valid=%b want 0", valid);
    end
  endtask

  task automatic test_priority();
    tick(8'h00, 1'b0);
    tick(8'h02, 1'b0);
    tick(8'h02, 1'b0);
    tick(8'h42, 1'b0);
    checks++;
    if (!(valid === 1'b1 && Y === 3'd1 && pending === 8'h42)) begin
      errors++;
      $display("FAIL prio_hold: valid=%b Y=%0d pend=%h want 1 1 42",
               valid, Y, pending);
    end
    tick(8'h42, 1'b1);
    checks++;
    if (!(valid === 1'b1 && Y === 3'd6)) begin
      errors++;
      $display("FAIL prio_next: valid=%b Y=%0d want 1 6", valid, Y);
    end
    tick(8'h42, 1'b1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_end: valid=%b want 0", valid);
    end
  endtask

  task automatic test_overflow();
    tick(8'h00, 1'b0);
    tick(8'h10, 1'b0);
    tick(8'h10, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h10, 1'b0);
    checks++;
    if (!(overflow === 1'b1 && pending === 8'h10 && Y === 3'd4)) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b pend=%h Y=%0d want 1 10 4",
               overflow, pending, Y);
    end
    tick(8'h10, 1'b1);
    checks++;
    if (!(valid === 1'b0 && pending === 8'h00)) begin
      errors++;
      $display("FAIL ovf_single: valid=%b pend=%h want 0 00", valid, pending);
    end
    tick(8'h10, 1'b0);
    checks++;
    if (!(valid === 1'b0 && overflow === 1'b1)) begin
      errors++;
      $display("FAIL ovf_sticky: valid=%b ovf=%b want 0 1", valid, overflow);
    end
  endtask

  task automatic test_collision();
    do_reset();
    tick(8'h04, 1'b0);
    tick(8'h04, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h04, 1'b1);
    checks++;
    if (!(valid === 1'b1 && Y === 3'd2 && pending === 8'h04 &&
          overflow === 1'b0)) begin
      errors++;
      $display("FAIL collide: valid=%b Y=%0d pend=%h ovf=%b want 1 2 04 0",
               valid, Y, pending, overflow);
    end
    tick(8'h04, 1'b1);
    checks++;
    if (!(valid === 1'b0 && pending === 8'h00)) begin
      errors++;
      $display("FAIL collide_end: valid=%b pend=%h want 0 00", valid, pending);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic r;
    do_reset();
    d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      d = d ^ 8'($urandom & $urandom & $urandom);
      r = ($urandom_range(0, 3) != 0);
      tick(d, r);
      checks++;
      if ({valid, pending, overflow} !== {m_valid, m_pend, m_ovf} ||
          (valid && Y !== m_y)) begin
        errors++;
        $display("FAIL rand%0d: v=%b Y=%0d p=%h o=%b want v=%b Y=%0d p=%h o=%b",
                 i, valid, Y, pending, overflow, m_valid, m_y, m_pend, m_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    D = 8'd0;
    ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_priority();
    test_overflow();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
